hx711_emulator: RTL and testbench
=================================

Name: hx711_emulator

Overview:
- Synthesizable model of the HX711 ADC's serial side: responds to a master-generated SCK and drives DOUT with 24-bit two's-complement samples, MSB first.
- Decodes the 25/26/27-pulse gain selection and the SCK-high power-down condition.
- Sits on the FPGA fabric as a hardware-in-loop stand-in for the load-cell ADC, so the existing HX711 master driver and the scale software can be exercised without an analog front end.

Parameters:
- SYNC_STAGES, 2, flip-flop stages synchronizing the sclk input (minimum 2).
- PD_CYC, 6000, clk cycles of continuous sclk high that force power-down (60 us at 100 MHz).
- END_GAP_CYC, 200, clk cycles of sclk low after at least one pulse that close a frame.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sample_data  in  24  next conversion result, two's complement.
- sample_valid  in  1  one-cycle strobe that loads sample_data.
- sclk  in  1  serial clock from master; asynchronous to clk.
- dout  out  1  serial data / not-ready line to master.
- gain_sel  out  2  00 = A/128, 01 = B/32, 10 = A/64.
- data_ready  out  1  high while a sample is waiting to be read (dout low).
- powered_down  out  1  high in power-down.
- frame_done_tick  out  1  one-cycle pulse on a valid frame end.
- frame_err_tick  out  1  one-cycle pulse on an invalid pulse count.
- overrun_tick  out  1  one-cycle pulse when a pending sample is overwritten.

Behaviour:
- Reset values: dout = 1, gain_sel = 00, all other outputs 0. State = NOTREADY, pulse count = 0, pending slot empty.
- Reset can assert mid-frame or in power-down; it returns to the reset state immediately.
- sclk is synchronized through SYNC_STAGES flip-flops. Rise and fall are detected on the synchronized value.
- dout reacts to a pin-level sclk rise within SYNC_STAGES+1 clk cycles. The master's SCK half-period must therefore be at least SYNC_STAGES+2 clk cycles.

State machine:
- NOTREADY: dout = 1. On sample_valid, load the shift register and go to READY.
- READY: dout = 0, data_ready = 1.
  - On sample_valid, overwrite the shift register; no overrun is flagged.
  - On an sclk rise, drive dout = sr[23], set count = 1, go to SHIFT.
- SHIFT: on each sclk rise, increment count.
  - Counts 2..24: drive the next bit (sr shifted left).
  - Count 25 and above: dout = 1.
  - While sclk stays low for END_GAP_CYC cycles, go to FRAME_END.
- FRAME_END (one cycle):
  - Count 25 -> gain 00, count 26 -> gain 01, count 27 -> gain 10; pulse frame_done_tick.
  - Any other count: gain unchanged; pulse frame_err_tick.
  - If a pending sample exists, move it into sr and go to READY; otherwise go to NOTREADY.
- Pending slot during SHIFT: sample_valid fills a 1-deep pending slot. A second sample_valid while the slot is full overwrites it and pulses overrun_tick.
- Power-down, from any state: sclk high for PD_CYC consecutive cycles -> PWRDN.
  - In PWRDN: dout = 1, powered_down = 1, pending slot cleared, sample_valid ignored.
  - On an sclk fall: gain_sel = 00 (power-on default), go to NOTREADY.
- Simultaneous events:
  - sample_valid in the FRAME_END cycle goes to the pending slot first, then is promoted.
  - The power-down threshold has priority over all other transitions.
- Counters saturate: pulse count at 63, high timer at PD_CYC, gap timer at END_GAP_CYC.

Optional Feature:
- HX711_EMU_SCLK_FILTER_EN: when defined, an sclk edge is accepted only after the synchronized level has held for 3 consecutive clk cycles. This suppresses glitches and adds 2 cycles of latency (minimum half-period becomes SYNC_STAGES+4).
- When undefined, every synchronized transition is an edge.

Decomposition:
- Package hx711_pkg holds:
  - gain_t enum (GAIN_A128 = 2'b00, GAIN_B32 = 2'b01, GAIN_A64 = 2'b10);
  - state_t enum (NOTREADY, READY, SHIFT, FRAME_END, PWRDN);
  - constants HX711_DATA_BITS = 24, HX711_PULSES_A128 = 25, HX711_PULSES_B32 = 26, HX711_PULSES_A64 = 27.
- One sub-module, sclk_sync_edge: synchronizer, optional filter, and rise/fall detector.

Test Plan:
- Load 24'hA5C3F0, then 25 SCK pulses at half-period 10 -> master reads A5C3F0; dout = 1 after pulse 25; frame_done_tick; gain_sel = 00.
- Load 24'h800001, then 26 pulses -> read 800001; gain_sel = 01. Repeat with 27 pulses -> gain_sel = 10.
- 20 pulses then idle -> frame_err_tick; gain_sel unchanged; return to NOTREADY (dout = 1).
- During SHIFT, two sample_valid strobes (0x000111, then 0x000222) -> one overrun_tick; next frame reads 000222.
- Hold sclk high for PD_CYC cycles -> powered_down = 1, dout = 1; sclk low -> gain_sel = 00, state NOTREADY.
- Assert reset_n low mid-frame at bit 12 -> dout = 1 and all outputs return to reset values in the same cycle.

Source files
------------

// File: rtl/hx711_pkg.sv
// Shared types and constants for the HX711 serial-side emulator.
package hx711_pkg;

    localparam int unsigned HX711_DATA_BITS   = 24;
    localparam int unsigned HX711_PULSES_A128 = 25;
    localparam int unsigned HX711_PULSES_B32  = 26;
    localparam int unsigned HX711_PULSES_A64  = 27;
    localparam int unsigned HX711_CNT_W       = 6;

    typedef enum logic [1:0] {
        GAIN_A128 = 2'b00,
        GAIN_B32  = 2'b01,
        GAIN_A64  = 2'b10
    } gain_t;

    typedef enum logic [2:0] {
        NOTREADY,
        READY,
        SHIFT,
        FRAME_END,
        PWRDN
    } state_t;

endpackage

// File: rtl/hx711_emulator_sclk_sync_edge.sv
// SCLK synchronizer with rise/fall detection; optional 3-cycle hold filter
// enabled by HX711_EMU_SCLK_FILTER_EN.
module sclk_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sclk,
    output logic level_c,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_q;
    logic                   level_d;
    logic                   sync_lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef HX711_EMU_SCLK_FILTER_EN
    logic [1:0] hist_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) hist_q <= '0;
        else          hist_q <= {hist_q[0], sync_lvl};
    end

    // Accept a new level only once it has been stable for three samples.
    always_comb begin
        level_d = level_q;
        if (sync_lvl == hist_q[0] && sync_lvl == hist_q[1]) level_d = sync_lvl;
    end
`else
    always_comb begin
        level_d = sync_lvl;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sclk};
            level_q <= level_d;
        end
    end

    assign level_c = level_d;
    assign rise_c  = level_d & ~level_q;
    assign fall_c  = ~level_d & level_q;

endmodule

// File: rtl/hx711_emulator.sv
// HX711 serial-side emulator: serves 24-bit samples on DOUT, decodes gain
// pulse count and SCK-high power-down. Optional HX711_EMU_SCLK_FILTER_EN.
module hx711_emulator
    import hx711_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PD_CYC      = 6000,
    parameter int unsigned END_GAP_CYC = 200
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] sample_data,
    input  logic        sample_valid,
    input  logic        sclk,
    output logic        dout,
    output logic [1:0]  gain_sel,
    output logic        data_ready,
    output logic        powered_down,
    output logic        frame_done_tick,
    output logic        frame_err_tick,
    output logic        overrun_tick
);

    localparam int unsigned HI_W  = $clog2(PD_CYC + 1);
    localparam int unsigned GAP_W = $clog2(END_GAP_CYC + 1);
    localparam int unsigned DW    = HX711_DATA_BITS;
    localparam int unsigned CW    = HX711_CNT_W;

    logic sclk_lvl, sclk_rise, sclk_fall;

    sclk_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .sclk    (sclk),
        .level_c (sclk_lvl),
        .rise_c  (sclk_rise),
        .fall_c  (sclk_fall)
    );

    state_t          state_q, state_d;
    logic [DW-1:0]   sr_q, sr_d, pend_q, pend_d;
    logic            pend_vld_q, pend_vld_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [HI_W-1:0] hi_q, hi_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    gain_t           gain_q, gain_d;
    logic            dout_q, dout_d;
    logic            rdy_q, rdy_d, pd_q, pd_d;
    logic            done_q, done_d, err_q, err_d, ovr_q, ovr_d;
    logic            pend_in_vld;
    logic [DW-1:0]   pend_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= NOTREADY;
            sr_q       <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            cnt_q      <= '0;
            hi_q       <= '0;
            gap_q      <= '0;
            gain_q     <= GAIN_A128;
            dout_q     <= 1'b1;
            rdy_q      <= 1'b0;
            pd_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            gap_q      <= gap_d;
            gain_q     <= gain_d;
            dout_q     <= dout_d;
            rdy_q      <= rdy_d;
            pd_q       <= pd_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        cnt_d      = cnt_q;
        gain_d     = gain_q;
        dout_d     = dout_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        ovr_d      = 1'b0;
        pend_in_vld = pend_vld_q | sample_valid;
        pend_in     = sample_valid ? sample_data : pend_q;

        // Saturating high-level and end-of-frame gap timers.
        hi_d = '0;
        if (sclk_lvl) hi_d = (hi_q == HI_W'(PD_CYC)) ? hi_q : hi_q + HI_W'(1);
        gap_d = '0;
        if (state_q == SHIFT && !sclk_lvl)
            gap_d = (gap_q == GAP_W'(END_GAP_CYC)) ? gap_q : gap_q + GAP_W'(1);

        case (state_q)
            NOTREADY: begin
                dout_d = 1'b1;
                if (sample_valid) begin
                    sr_d    = sample_data;
                    dout_d  = 1'b0;
                    state_d = READY;
                end
            end
            READY: begin
                dout_d = 1'b0;
                if (sample_valid) sr_d = sample_data;
                if (sclk_rise) begin
                    dout_d  = sr_d[DW-1];
                    sr_d    = {sr_d[DW-2:0], 1'b0};
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (sample_valid) begin
                    ovr_d      = pend_vld_q;
                    pend_d     = sample_data;
                    pend_vld_d = 1'b1;
                end
                if (sclk_rise) begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
                    if (cnt_d <= CW'(DW)) begin
                        dout_d = sr_q[DW-1];
                        sr_d   = {sr_q[DW-2:0], 1'b0};
                    end else begin
                        dout_d = 1'b1;
                    end
                end
                if (gap_d == GAP_W'(END_GAP_CYC)) state_d = FRAME_END;
            end
            FRAME_END: begin
                done_d = 1'b1;
                case (cnt_q)
                    CW'(HX711_PULSES_A128): gain_d = GAIN_A128;
                    CW'(HX711_PULSES_B32):  gain_d = GAIN_B32;
                    CW'(HX711_PULSES_A64):  gain_d = GAIN_A64;
                    default: begin
                        done_d = 1'b0;
                        err_d  = 1'b1;
                    end
                endcase
                // A strobe landing here joins the slot before promotion.
                ovr_d      = sample_valid & pend_vld_q;
                cnt_d      = '0;
                pend_vld_d = 1'b0;
                if (pend_in_vld) begin
                    sr_d    = pend_in;
                    dout_d  = 1'b0;
                    state_d = READY;
                end else begin
                    dout_d  = 1'b1;
                    state_d = NOTREADY;
                end
            end
            PWRDN: begin
                dout_d     = 1'b1;
                pend_vld_d = 1'b0;
                if (sclk_fall) begin
                    gain_d  = GAIN_A128;
                    state_d = NOTREADY;
                end
            end
            default: state_d = NOTREADY;
        endcase

        if (hi_d == HI_W'(PD_CYC) && state_q != PWRDN) begin
            state_d    = PWRDN;
            dout_d     = 1'b1;
            pend_vld_d = 1'b0;
            cnt_d      = '0;
            done_d     = 1'b0;
            err_d      = 1'b0;
            ovr_d      = 1'b0;
        end

        rdy_d = (state_d == READY);
        pd_d  = (state_d == PWRDN);
    end

    assign dout            = dout_q;
    assign gain_sel        = gain_q;
    assign data_ready      = rdy_q;
    assign powered_down    = pd_q;
    assign frame_done_tick = done_q;
    assign frame_err_tick  = err_q;
    assign overrun_tick    = ovr_q;

endmodule

// File: tb/tb_hx711_emulator.sv
// Self-checking bench for hx711_emulator: acts as an HX711 master and
// compares against expected words, gain table and tick counts.
module tb_hx711_emulator;

    localparam int unsigned SYNC = 2;
    localparam int unsigned PD   = 6000;
    localparam int unsigned GAP  = 200;
`ifdef HX711_EMU_SCLK_FILTER_EN
    localparam int unsigned HALF = 12;
`else
    localparam int unsigned HALF = 10;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [23:0] sample_data;
    logic        sample_valid;
    logic        sclk;
    logic        dout;
    logic [1:0]  gain_sel;
    logic        data_ready, powered_down;
    logic        frame_done_tick, frame_err_tick, overrun_tick;

    int checks = 0;
    int fails  = 0;
    int n_done = 0, n_err = 0, n_ovr = 0;
    logic [1:0]  exp_gain;
    logic [23:0] rd_word;
    int          pidx;

    hx711_emulator #(.SYNC_STAGES(SYNC), .PD_CYC(PD), .END_GAP_CYC(GAP)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .sample_data     (sample_data),
        .sample_valid    (sample_valid),
        .sclk            (sclk),
        .dout            (dout),
        .gain_sel        (gain_sel),
        .data_ready      (data_ready),
        .powered_down    (powered_down),
        .frame_done_tick (frame_done_tick),
        .frame_err_tick  (frame_err_tick),
        .overrun_tick    (overrun_tick)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done_tick) n_done++;
        if (frame_err_tick)  n_err++;
        if (overrun_tick)    n_ovr++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [23:0] w);
        @(negedge clk);
        sample_data  = w;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    // Master-side pulses: shift in data bits, expect dout high past bit 24.
    task automatic clock_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            sclk = 1'b1;
            wait_clk(HALF);
            pidx++;
            if (pidx <= 24) begin
                rd_word = {rd_word[22:0], dout};
            end else begin
                checks++;
                if (dout !== 1'b1) begin
                    fails++;
                    $display("FAIL tail_dout pulse %0d: got %b expected 1", pidx, dout);
                end
            end
            sclk = 1'b0;
            wait_clk(HALF);
        end
    endtask

    task automatic wait_frame_end(output int kind);
        int d0, e0;
        d0 = n_done;
        e0 = n_err;
        kind = 0;
        for (int i = 0; i < 2 * GAP; i++) begin
            wait_clk(1);
            if (n_done != d0) begin kind = 1; break; end
            if (n_err != e0)  begin kind = 2; break; end
        end
    endtask

    function automatic logic [1:0] gain_for(input int n, input logic [1:0] cur);
        if (n == 25) return 2'b00;
        if (n == 26) return 2'b01;
        if (n == 27) return 2'b10;
        return cur;
    endfunction

    task automatic test_reset();
        checks++;
        if ({dout, gain_sel, data_ready, powered_down, frame_done_tick, frame_err_tick, overrun_tick} !== 8'b1_00_00000) begin
            fails++;
            $display("FAIL reset_outputs: got dout=%b gain=%b rdy=%b pd=%b ticks=%b%b%b expected 1 00 0 0 000",
                     dout, gain_sel, data_ready, powered_down, frame_done_tick, frame_err_tick, overrun_tick);
        end
    endtask

    task automatic test_frame(input logic [23:0] w, input int n, input bit preload);
        int kind, exp_kind;
        if (preload) load(~w);
        load(w);
        wait_clk(4);
        checks++;
        if (data_ready !== 1'b1 || dout !== 1'b0) begin
            fails++;
            $display("FAIL ready_state: got rdy=%b dout=%b expected rdy=1 dout=0", data_ready, dout);
        end
        pidx = 0;
        rd_word = '0;
        clock_pulses(n);
        if (n >= 24) begin
            checks++;
            if (rd_word !== w) begin
                fails++;
                $display("FAIL read_word n=%0d: got %h expected %h", n, rd_word, w);
            end
        end
        wait_frame_end(kind);
        exp_kind = (n >= 25 && n <= 27) ? 1 : 2;
        exp_gain = gain_for(n, exp_gain);
        checks++;
        if (kind != exp_kind) begin
            fails++;
            $display("FAIL frame_tick n=%0d: got kind %0d expected %0d", n, kind, exp_kind);
        end
        checks++;
        if (gain_sel !== exp_gain) begin
            fails++;
            $display("FAIL gain_sel n=%0d: got %b expected %b", n, gain_sel, exp_gain);
        end
        wait_clk(2);
        checks++;
        if (dout !== 1'b1 || data_ready !== 1'b0) begin
            fails++;
            $display("FAIL notready_after n=%0d: got dout=%b rdy=%b expected 1 0", n, dout, data_ready);
        end
    endtask

    task automatic test_overrun();
        int kind, o0;
        logic [23:0] w0;
        w0 = 24'($urandom);
        o0 = n_ovr;
        load(w0);
        wait_clk(4);
        pidx = 0;
        rd_word = '0;
        clock_pulses(3);
        load(24'h000111);
        wait_clk(2);
        load(24'h000222);
        wait_clk(2);
        checks++;
        if (n_ovr - o0 != 1) begin
            fails++;
            $display("FAIL overrun_count: got %0d expected 1", n_ovr - o0);
        end
        clock_pulses(22);
        checks++;
        if (rd_word !== w0) begin
            fails++;
            $display("FAIL overrun_first_word: got %h expected %h", rd_word, w0);
        end
        wait_frame_end(kind);
        exp_gain = 2'b00;
        checks++;
        if (kind != 1) begin
            fails++;
            $display("FAIL overrun_frame_tick: got kind %0d expected 1", kind);
        end
        wait_clk(2);
        checks++;
        if (data_ready !== 1'b1 || dout !== 1'b0) begin
            fails++;
            $display("FAIL pending_promoted: got rdy=%b dout=%b expected 1 0", data_ready, dout);
        end
        pidx = 0;
        rd_word = '0;
        clock_pulses(25);
        wait_frame_end(kind);
        checks++;
        if (rd_word !== 24'h000222 || kind != 1) begin
            fails++;
            $display("FAIL pending_word: got %h kind %0d expected 000222 kind 1", rd_word, kind);
        end
        checks++;
        if (n_ovr - o0 != 1) begin
            fails++;
            $display("FAIL overrun_total: got %0d expected 1", n_ovr - o0);
        end
    endtask

    task automatic test_powerdown();
        test_frame(24'($urandom), 26, 1'b0);
        load(24'($urandom));
        sclk = 1'b1;
        wait_clk(PD - 20);
        checks++;
        if (powered_down !== 1'b0) begin
            fails++;
            $display("FAIL pd_early: got %b expected 0", powered_down);
        end
        wait_clk(40);
        checks++;
        if (powered_down !== 1'b1 || dout !== 1'b1 || data_ready !== 1'b0) begin
            fails++;
            $display("FAIL pd_entered: got pd=%b dout=%b rdy=%b expected 1 1 0", powered_down, dout, data_ready);
        end
        load(24'($urandom));
        wait_clk(2);
        sclk = 1'b0;
        wait_clk(10);
        exp_gain = 2'b00;
        checks++;
        if (powered_down !== 1'b0 || gain_sel !== exp_gain || dout !== 1'b1 || data_ready !== 1'b0) begin
            fails++;
            $display("FAIL pd_exit: got pd=%b gain=%b dout=%b rdy=%b expected 0 00 1 0",
                     powered_down, gain_sel, dout, data_ready);
        end
    endtask

    task automatic test_reset_midframe();
        test_frame(24'($urandom), 27, 1'b0);
        load(24'($urandom));
        wait_clk(4);
        pidx = 0;
        rd_word = '0;
        clock_pulses(11);
        sclk = 1'b1;
        wait_clk(HALF);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({dout, gain_sel, data_ready, powered_down, frame_done_tick, frame_err_tick, overrun_tick} !== 8'b1_00_00000) begin
            fails++;
            $display("FAIL reset_midframe: got dout=%b gain=%b rdy=%b pd=%b expected 1 00 0 0",
                     dout, gain_sel, data_ready, powered_down);
        end
        sclk = 1'b0;
        wait_clk(5);
        reset_n = 1'b1;
        exp_gain = 2'b00;
        wait_clk(5);
        checks++;
        if (dout !== 1'b1 || data_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_recover_idle: got dout=%b rdy=%b expected 1 0", dout, data_ready);
        end
        test_frame(24'($urandom), 25, 1'b0);
    endtask

    task automatic test_random_frames();
        int r, n;
        for (int k = 0; k < 6; k++) begin
            r = int'($urandom_range(0, 5));
            case (r)
                0, 1, 2: n = 25 + r;
                3:       n = int'($urandom_range(1, 23));
                4:       n = int'($urandom_range(28, 40));
                default: n = 24;
            endcase
            test_frame(24'($urandom), n, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        sclk         = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        exp_gain     = 2'b00;
        wait_clk(3);
        test_reset();
        reset_n = 1'b1;
        wait_clk(3);
        test_reset();
        test_frame(24'hA5C3F0, 25, 1'b0);
        test_frame(24'h800001, 26, 1'b0);
        test_frame(24'h800001, 27, 1'b0);
        test_frame(24'($urandom), 20, 1'b0);
        test_frame(24'h123456, 25, 1'b1);
        test_overrun();
        test_powerdown();
        test_reset_midframe();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
